hyper_mem_emu: RTL and testbench

HYPER_MEM_EMU -- requirements
Module: hyper_mem_emu

---
 rtl/hyper_mem_emu.sv | 225 ++++++++++++++++++++++
 tb/tb_hyper_mem_emu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_mem_emu.sv
// Behavioural HyperRAM device model: NumChips chips share one bus, and the bus clock is
// oversampled on clk_i so that every level change of hyper_ck_i is one bus edge.
module hyper_mem_emu #(
   parameter int unsigned NumChips = 2,
   parameter int unsigned MemWords = 1024,
   parameter logic [15:0] Cr0Reset = 16'h8F1F
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                hyper_reset_ni,
   input  logic [NumChips-1:0] hyper_cs_ni,
   input  logic                hyper_ck_i,
   input  logic [7:0]          hyper_dq_i,
   input  logic                hyper_rwds_i,
   output logic [7:0]          hyper_dq_o,
   output logic                hyper_dq_oe_o,
   output logic                hyper_rwds_o,
   output logic                hyper_rwds_oe_o,
   output logic                err_o
);
   localparam int unsigned AW = $clog2(MemWords);
   localparam int unsigned CW = (NumChips > 1) ? $clog2(NumChips) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CA    = 3'd1,
      LAT   = 3'd2,
      RD    = 3'd3,
      WR    = 3'd4,
      REGWR = 3'd5
   } state_e;

   state_e            state_q;
   logic              ck_q;
   logic [5:0]        cnt_q;
   logic [39:0]       ca_q;
   logic [CW-1:0]     chip_q;
   logic [AW-1:0]     addr_q;
   logic              is_rd_q, is_reg_q, linear_q, byte_sel_q;
   logic [7:0]        hi_byte_q;
   logic              hi_mask_q;
   logic [15:0]       cr0_q;
   logic [7:0]        dq_q;
   logic              dq_oe_q, rwds_q, rwds_oe_q, err_q;
   logic [15:0]       mem_q [NumChips][MemWords];

   logic [NumChips-1:0] cs_low_s;
   logic                any_low_s, multi_low_s, cs_hi_s, bus_edge_s, we_s, ca_unused_s;
   logic [CW-1:0]       sel_chip_s;
   logic [47:0]         ca_full_s;
   logic [31:0]         wa_s;
   logic [15:0]         mem_word_s, rd_word_s, wdata_s;
   logic [AW-1:0]       next_addr_s;
   logic [5:0]          lat_last_s;

   // Total latency edges: 2*L, or 4*L when CR0[3] requests doubled latency.
   function automatic logic [5:0] lat_edges(input logic [15:0] cr0);
      logic [2:0] l;
      case (cr0[7:4])
         4'd0:    l = 3'd5;
         4'd1:    l = 3'd6;
         4'd2:    l = 3'd7;
         4'd14:   l = 3'd3;
         4'd15:   l = 3'd4;
         default: l = 3'd6;
      endcase
      return cr0[3] ? {1'b0, l, 2'b00} : {2'b00, l, 1'b0};
   endfunction

   // Chip select decode, edge detect, address arithmetic and write data merge.
   always_comb begin
      cs_low_s    = ~hyper_cs_ni;
      any_low_s   = |cs_low_s;
      multi_low_s = |(cs_low_s & (cs_low_s - NumChips'(1)));
      sel_chip_s  = '0;
      for (int i = NumChips - 1; i >= 0; i--) begin
         sel_chip_s = hyper_cs_ni[i] ? sel_chip_s : CW'(i);
      end
      cs_hi_s     = hyper_cs_ni[chip_q];
      bus_edge_s  = hyper_ck_i ^ ck_q;
      ca_full_s   = {ca_q, hyper_dq_i};
      wa_s        = {ca_full_s[44:16], ca_full_s[2:0]};
      ca_unused_s = ^{ca_full_s, wa_s};
      mem_word_s  = mem_q[chip_q][addr_q];
      rd_word_s   = is_reg_q ? cr0_q : mem_word_s;
      next_addr_s = linear_q ? (addr_q + AW'(1)) : {addr_q[AW-1:4], addr_q[3:0] + 4'd1};
      lat_last_s  = lat_edges(cr0_q) - 6'd1;
      // A word is committed only on its second byte, so aborted words never reach memory.
      we_s        = rst_ni & hyper_reset_ni & ~cs_hi_s & bus_edge_s & byte_sel_q & (state_q == WR);
      wdata_s     = {hi_mask_q ? mem_word_s[15:8] : hi_byte_q,
                     hyper_rwds_i ? mem_word_s[7:0] : hyper_dq_i};
   end

   // Storage array, deliberately without reset.
   always_ff @(posedge clk_i) begin
      if (we_s) begin
         mem_q[chip_q][addr_q] <= wdata_s;
      end
   end

   // Bus sequencer: transaction FSM, CR0 and the registered pad outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ck_q       <= hyper_ck_i;
         cnt_q      <= 6'd0;
         ca_q       <= 40'd0;
         chip_q     <= '0;
         addr_q     <= '0;
         is_rd_q    <= 1'b0;
         is_reg_q   <= 1'b0;
         linear_q   <= 1'b0;
         byte_sel_q <= 1'b0;
         hi_byte_q  <= 8'd0;
         hi_mask_q  <= 1'b0;
         cr0_q      <= Cr0Reset;
         dq_q       <= 8'd0;
         dq_oe_q    <= 1'b0;
         rwds_q     <= 1'b0;
         rwds_oe_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ck_q <= hyper_ck_i;
         if (multi_low_s) begin
            err_q <= 1'b1;
         end
         if (!hyper_reset_ni) begin
            state_q   <= IDLE;
            cr0_q     <= Cr0Reset;
            dq_oe_q   <= 1'b0;
            rwds_oe_q <= 1'b0;
         end else if ((state_q != IDLE) && cs_hi_s) begin
            state_q   <= IDLE;
            dq_oe_q   <= 1'b0;
            rwds_oe_q <= 1'b0;
            if (state_q == CA) begin
               err_q <= 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (any_low_s) begin
                     state_q   <= CA;
                     chip_q    <= sel_chip_s;
                     cnt_q     <= 6'd0;
                     rwds_oe_q <= 1'b1;
                     rwds_q    <= cr0_q[3];
                  end
               end
               CA: begin
                  rwds_q <= cr0_q[3];
                  if (bus_edge_s) begin
                     ca_q <= ca_full_s[39:0];
                     if (cnt_q == 6'd5) begin
                        is_rd_q    <= ca_full_s[47];
                        is_reg_q   <= ca_full_s[46];
                        linear_q   <= ca_full_s[45];
                        addr_q     <= wa_s[AW-1:0];
                        cnt_q      <= 6'd0;
                        byte_sel_q <= 1'b0;
                        rwds_oe_q  <= 1'b0;
                        state_q    <= (!ca_full_s[47] && ca_full_s[46]) ? REGWR : LAT;
                     end else begin
                        cnt_q <= cnt_q + 6'd1;
                     end
                  end
               end
               LAT: begin
                  if (bus_edge_s) begin
                     if (cnt_q == lat_last_s) begin
                        cnt_q   <= 6'd0;
                        state_q <= is_rd_q ? RD : WR;
                     end else begin
                        cnt_q <= cnt_q + 6'd1;
                     end
                  end
               end
               RD: begin
                  if (bus_edge_s) begin
                     dq_q       <= byte_sel_q ? rd_word_s[7:0] : rd_word_s[15:8];
                     rwds_q     <= ~byte_sel_q;
                     dq_oe_q    <= 1'b1;
                     rwds_oe_q  <= 1'b1;
                     byte_sel_q <= ~byte_sel_q;
                     if (byte_sel_q) begin
                        addr_q <= next_addr_s;
                     end
                  end
               end
               WR: begin
                  if (bus_edge_s) begin
                     byte_sel_q <= ~byte_sel_q;
                     if (byte_sel_q) begin
                        addr_q <= next_addr_s;
                     end else begin
                        hi_byte_q <= hyper_dq_i;
                        hi_mask_q <= hyper_rwds_i;
                     end
                  end
               end
               REGWR: begin
                  if (bus_edge_s) begin
                     if (cnt_q == 6'd0) begin
                        hi_byte_q <= hyper_dq_i;
                        cnt_q     <= 6'd1;
                     end else if (cnt_q == 6'd1) begin
                        cr0_q <= {hi_byte_q, hyper_dq_i};
                        cnt_q <= 6'd2;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign hyper_dq_o      = dq_q;
   assign hyper_dq_oe_o   = dq_oe_q;
   assign hyper_rwds_o    = rwds_q;
   assign hyper_rwds_oe_o = rwds_oe_q;
   assign err_o           = err_q;
endmodule

// File: tb/tb_hyper_mem_emu.sv
// Directed bench for hyper_mem_emu: bus transactions built edge by edge, expected values
// hand-computed, CR0 and latency tracked by a tiny model of the register.
module tb_hyper_mem_emu;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hreset_n = 1'b1;
   logic [1:0] cs_n = 2'b11;
   logic       ck = 1'b0;
   logic [7:0] dq = 8'd0;
   logic       rwds = 1'b0;
   logic [7:0] dq_o;
   logic       dq_oe, rwds_o, rwds_oe, err;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] cr0_m = 16'h8F1F;
   logic [15:0] rd_buf [8];
   logic [15:0] wr_buf [8];
   logic [1:0]  wm_buf [8];

   hyper_mem_emu dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .hyper_reset_ni  (hreset_n),
      .hyper_cs_ni     (cs_n),
      .hyper_ck_i      (ck),
      .hyper_dq_i      (dq),
      .hyper_rwds_i    (rwds),
      .hyper_dq_o      (dq_o),
      .hyper_dq_oe_o   (dq_oe),
      .hyper_rwds_o    (rwds_o),
      .hyper_rwds_oe_o (rwds_oe),
      .err_o           (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic int lat_model(input logic [15:0] c);
      int l;
      case (c[7:4])
         4'd0:    l = 5;
         4'd1:    l = 6;
         4'd2:    l = 7;
         4'd14:   l = 3;
         4'd15:   l = 4;
         default: l = 6;
      endcase
      return c[3] ? 4 * l : 2 * l;
   endfunction

   function automatic logic [47:0] mk_ca(input logic rd, input logic rg, input logic lin,
                                         input logic [31:0] a);
      return {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
   endfunction

   // One bus edge; each ck level is held for two clk cycles.
   task automatic bus_edge(input logic [7:0] d, input logic m);
      @(negedge clk);
      @(negedge clk);
      dq   = d;
      rwds = m;
      ck   = ~ck;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int chip);
      @(negedge clk);
      cs_n[chip] = 1'b0;
      @(posedge clk);
      #1;
      check_val("ca_rwds", {14'd0, rwds_oe, rwds_o}, {14'd0, 1'b1, cr0_m[3]});
   endtask

   task automatic stop();
      @(negedge clk);
      cs_n = 2'b11;
      @(posedge clk);
      #1;
      check_val("idle_oe", {14'd0, dq_oe, rwds_oe}, 16'd0);
   endtask

   task automatic send_ca(input logic [47:0] ca);
      for (int i = 0; i < 6; i++) begin
         bus_edge(ca[47-8*i -: 8], 1'b0);
      end
   endtask

   task automatic lat_wait();
      repeat (lat_model(cr0_m)) bus_edge(8'h00, 1'b0);
   endtask

   task automatic do_write(input int chip, input logic lin, input logic [31:0] a, input int n);
      start(chip);
      send_ca(mk_ca(1'b0, 1'b0, lin, a));
      lat_wait();
      for (int w = 0; w < n; w++) begin
         bus_edge(wr_buf[w][15:8], wm_buf[w][1]);
         bus_edge(wr_buf[w][7:0], wm_buf[w][0]);
      end
      stop();
   endtask

   task automatic do_read(input int chip, input logic rg, input logic lin, input logic [31:0] a,
                          input int n);
      start(chip);
      send_ca(mk_ca(1'b1, rg, lin, a));
      lat_wait();
      check_val("lat_quiet", {15'd0, dq_oe}, 16'd0);
      for (int w = 0; w < n; w++) begin
         bus_edge(8'h00, 1'b0);
         rd_buf[w][15:8] = dq_o;
         check_val("rd_strobe_hi", {13'd0, dq_oe, rwds_oe, rwds_o}, 16'd7);
         bus_edge(8'h00, 1'b0);
         rd_buf[w][7:0] = dq_o;
         check_val("rd_strobe_lo", {13'd0, dq_oe, rwds_oe, rwds_o}, 16'd6);
      end
      stop();
   endtask

   task automatic do_regwr(input logic [15:0] v, input logic [7:0] extra);
      start(0);
      send_ca(mk_ca(1'b0, 1'b1, 1'b0, 32'd0));
      bus_edge(v[15:8], 1'b0);
      bus_edge(v[7:0], 1'b1);
      bus_edge(extra, 1'b0);
      stop();
      cr0_m = v;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_outs", {4'd0, dq_o, dq_oe, rwds_o, rwds_oe, err}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      wr_buf[0] = 16'hA5A5; wr_buf[1] = 16'h1234; wm_buf[0] = 2'b00; wm_buf[1] = 2'b00;
      do_write(0, 1'b1, 32'h010, 2);
      do_read(0, 1'b0, 1'b1, 32'h010, 2);
      check_val("lin_rd0", rd_buf[0], 16'hA5A5);
      check_val("lin_rd1", rd_buf[1], 16'h1234);

      wr_buf[0] = 16'h1111; wr_buf[1] = 16'h2222;
      do_write(0, 1'b1, 32'h020, 2);
      wr_buf[0] = 16'hBEEF; wm_buf[0] = 2'b01; wr_buf[1] = 16'h3344; wm_buf[1] = 2'b10;
      do_write(0, 1'b1, 32'h020, 2);
      do_read(0, 1'b0, 1'b1, 32'h020, 2);
      check_val("mask_lo", rd_buf[0], 16'hBE11);
      check_val("mask_hi", rd_buf[1], 16'h2244);

      wm_buf[0] = 2'b00; wm_buf[1] = 2'b00;
      wr_buf[0] = 16'h0F0F; wr_buf[1] = 16'hF0F0;
      do_write(1, 1'b1, 32'h3FF, 2);
      wr_buf[0] = 16'h5A5A;
      do_write(1, 1'b1, 32'h010, 1);
      do_read(1, 1'b0, 1'b1, 32'h000, 1);
      check_val("lin_wrap", rd_buf[0], 16'hF0F0);
      do_read(0, 1'b0, 1'b1, 32'h010, 1);
      check_val("chip0_iso", rd_buf[0], 16'hA5A5);
      do_read(1, 1'b0, 1'b1, 32'h010, 1);
      check_val("chip1_iso", rd_buf[0], 16'h5A5A);

      do_regwr(16'hE01F, 8'h00);
      do_read(0, 1'b1, 1'b0, 32'h000, 1);
      check_val("cr0_e01f", rd_buf[0], 16'hE01F);
      do_regwr(16'h8FE0, 8'h12);
      do_read(0, 1'b1, 1'b0, 32'h123, 1);
      check_val("cr0_8fe0", rd_buf[0], 16'h8FE0);

      wr_buf[0] = 16'hC00E; wr_buf[1] = 16'hC00F; wr_buf[2] = 16'hC000; wr_buf[3] = 16'hC001;
      wm_buf[2] = 2'b00; wm_buf[3] = 2'b00;
      do_write(0, 1'b0, 32'h00E, 4);
      do_read(0, 1'b0, 1'b0, 32'h00E, 4);
      check_val("wrap_e", rd_buf[0], 16'hC00E);
      check_val("wrap_f", rd_buf[1], 16'hC00F);
      check_val("wrap_0", rd_buf[2], 16'hC000);
      check_val("wrap_1", rd_buf[3], 16'hC001);
      do_read(0, 1'b0, 1'b1, 32'h00F, 2);
      check_val("lin_cross_f", rd_buf[0], 16'hC00F);
      check_val("lin_cross_10", rd_buf[1], 16'hA5A5);

      wr_buf[0] = 16'h7777;
      do_write(0, 1'b1, 32'h030, 1);
      start(0);
      send_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h030));
      lat_wait();
      bus_edge(8'h12, 1'b0);
      stop();
      check_val("wr_abort_err", {15'd0, err}, 16'd0);
      start(0);
      send_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h030));
      lat_wait();
      bus_edge(8'h12, 1'b0);
      @(negedge clk);
      @(negedge clk);
      dq = 8'h34;
      ck = ~ck;
      cs_n = 2'b11;
      @(posedge clk);
      #1;
      check_val("cs_wins_oe", {14'd0, dq_oe, rwds_oe}, 16'd0);
      do_read(0, 1'b0, 1'b1, 32'h030, 1);
      check_val("abort_keep", rd_buf[0], 16'h7777);

      @(negedge clk);
      cs_n = 2'b00;
      @(posedge clk);
      #1;
      check_val("multi_cs_err", {15'd0, err}, 16'd1);
      @(negedge clk);
      cs_n = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      check_val("err_sticky", {15'd0, err}, 16'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_val("err_clear", {15'd0, err}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cr0_m = 16'h8F1F;
      start(0);
      bus_edge(8'h00, 1'b0);
      bus_edge(8'h00, 1'b0);
      bus_edge(8'h18, 1'b0);
      stop();
      check_val("ca_abort_err", {15'd0, err}, 16'd1);
      do_read(0, 1'b0, 1'b1, 32'h030, 1);
      check_val("ca_abort_keep", rd_buf[0], 16'h7777);

      do_regwr(16'h8FE0, 8'h00);
      @(negedge clk);
      hreset_n = 1'b0;
      @(negedge clk);
      hreset_n = 1'b1;
      cr0_m = 16'h8F1F;
      check_val("hrst_err_kept", {15'd0, err}, 16'd1);
      do_read(0, 1'b1, 1'b0, 32'h000, 1);
      check_val("hrst_cr0", rd_buf[0], 16'h8F1F);

      wr_buf[0] = 16'h0000; wr_buf[1] = 16'h6666;
      do_write(0, 1'b1, 32'h040, 2);
      start(0);
      send_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h040));
      lat_wait();
      bus_edge(8'h13, 1'b0);
      bus_edge(8'h57, 1'b0);
      bus_edge(8'hAB, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      cs_n = 2'b11;
      @(posedge clk);
      #1;
      check_val("rst_mid_outs", {4'd0, dq_o, dq_oe, rwds_o, rwds_oe, err}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cr0_m = 16'h8F1F;
      do_read(0, 1'b1, 1'b0, 32'h000, 1);
      check_val("rst_cr0", rd_buf[0], 16'h8F1F);
      do_read(0, 1'b0, 1'b1, 32'h040, 2);
      check_val("rst_done_word", rd_buf[0], 16'h1357);
      check_val("rst_pending", rd_buf[1], 16'h6666);
      do_read(0, 1'b0, 1'b1, 32'h010, 1);
      check_val("rst_earlier", rd_buf[0], 16'hA5A5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
